// File: rtl/tl_mon_pkg.sv
// Shared light codes, monitor states, fault causes and approach helpers for tl_conflict_monitor.
package tl_mon_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  typedef enum logic [1:0] {
    ST_ALLRED,
    ST_RUN,
    ST_FAULT
  } state_e;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_INVALID   = 3'd1;
  localparam logic [2:0] FC_CONFLICT  = 3'd2;
  localparam logic [2:0] FC_SHORT_YEL = 3'd3;
  localparam logic [2:0] FC_ILLEGAL   = 3'd4;
  localparam logic [2:0] FC_WDOG      = 3'd5;

  // Approaches 0 and 2 share axis A; 1 and 3 share axis B.
  function automatic logic isAxisA(input int idx);
    return (idx == 0) || (idx == 2);
  endfunction

  function automatic logic isLegal(input logic [2:0] code);
    return (code == LT_RED) || (code == LT_YEL) || (code == LT_GRN);
  endfunction

  function automatic logic [1:0] lowestIdx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tl_glitch_filter.sv
// 3-bit debounce: a registered code becomes the stable code once it has held for GLITCH_CYC cycles.
module tl_glitch_filter
  import tl_mon_pkg::*;
#(
  parameter int unsigned GLITCH_CYC = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] raw_i,
  output logic [2:0] stable_o
);

  localparam int unsigned CW = $clog2(GLITCH_CYC + 1);

  logic [2:0]    raw_q;
  logic [2:0]    stable_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any difference from the registered sample restarts the hold count.
  always_comb begin
    cnt_d = cnt_q;
    if (raw_i != raw_q) cnt_d = '0;
    else if (cnt_q != CW'(GLITCH_CYC)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      raw_q    <= LT_RED;
      stable_q <= LT_RED;
      cnt_q    <= '0;
    end else begin
      raw_q <= raw_i;
      cnt_q <= cnt_d;
      if (cnt_d == CW'(GLITCH_CYC)) stable_q <= raw_q;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/tl_conflict_monitor.sv
// Safety stage between the light PIOs and the lamp drivers; latches faults and flashes red.
// Define TL_CONFLICT_MONITOR_WDOG_EN to add the software heartbeat watchdog (fault code 5).
module tl_conflict_monitor
  import tl_mon_pkg::*;
#(
  parameter int unsigned GLITCH_CYC     = 4,
  parameter int unsigned MIN_YELLOW_CYC = 150000000,
  parameter int unsigned ALLRED_CYC     = 50000000,
  parameter int unsigned FLASH_HALF_CYC = 25000000,
  parameter int unsigned WDOG_CYC       = 100000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [2:0] tl_0_in,
  input  logic [2:0] tl_1_in,
  input  logic [2:0] tl_2_in,
  input  logic [2:0] tl_3_in,
  input  logic       clear_fault,
  input  logic       wdog_kick,
  output logic [2:0] tl_0_out,
  output logic [2:0] tl_1_out,
  output logic [2:0] tl_2_out,
  output logic [2:0] tl_3_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_approach
);

  localparam int unsigned YW = $clog2(MIN_YELLOW_CYC + 1);

  logic [3:0][2:0]    rawIn;
  logic [3:0][2:0]    stable;
  logic [3:0][2:0]    prev_q;
  logic [3:0][2:0]    out_q;
  logic [3:0][YW-1:0] yelCnt_q;
  logic [31:0]        timer_q;
  state_e             state_q;
  logic [2:0]         code_q;
  logic [1:0]         appr_q;

  logic [3:0] invalidV, shortV, illegalV;
  logic       anyA, anyB, allRed;
  logic [2:0] detCode;
  logic [1:0] detAppr;

  assign rawIn = {tl_3_in, tl_2_in, tl_1_in, tl_0_in};

  for (genvar g = 0; g < 4; g++) begin : gFilt
    tl_glitch_filter #(.GLITCH_CYC(GLITCH_CYC)) uFilt (
      .clk_i   (clk_clk),
      .reset_i (reset_reset),
      .raw_i   (rawIn[g]),
      .stable_o(stable[g])
    );
  end

`ifdef TL_CONFLICT_MONITOR_WDOG_EN
  logic [31:0] wdogCnt_q;

  // Held at zero outside ST_RUN, so every entry into ST_RUN starts a fresh timeout.
  always_ff @(posedge clk_clk) begin
    if (reset_reset || wdog_kick || (state_q != ST_RUN)) wdogCnt_q <= '0;
    else if (wdogCnt_q != WDOG_CYC) wdogCnt_q <= wdogCnt_q + 32'd1;
  end
`else
  logic unusedWdog;
  assign unusedWdog = wdog_kick ^ (WDOG_CYC == 0);
`endif

  assign allRed = (stable == {4{LT_RED}});

  always_comb begin
    invalidV = '0;
    shortV   = '0;
    illegalV = '0;
    anyA     = 1'b0;
    anyB     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      invalidV[i] = !isLegal(stable[i]);
      if (stable[i] != prev_q[i]) begin
        if ((prev_q[i] == LT_YEL) && (stable[i] == LT_RED))
          shortV[i] = (yelCnt_q[i] < YW'(MIN_YELLOW_CYC));
        else if (!(((prev_q[i] == LT_RED) && (stable[i] == LT_GRN)) ||
                   ((prev_q[i] == LT_GRN) && (stable[i] == LT_YEL))))
          illegalV[i] = 1'b1;
      end
      if (stable[i] != LT_RED) begin
        if (isAxisA(i)) anyA = 1'b1;
        else            anyB = 1'b1;
      end
    end

    // Lower cause codes take priority, then the lowest approach index.
    detCode = FC_NONE;
    detAppr = 2'd0;
    if (|invalidV) begin
      detCode = FC_INVALID;
      detAppr = lowestIdx(invalidV);
    end else if (anyA && anyB) begin
      detCode = FC_CONFLICT;
    end else if (|shortV) begin
      detCode = FC_SHORT_YEL;
      detAppr = lowestIdx(shortV);
    end else if (|illegalV) begin
      detCode = FC_ILLEGAL;
      detAppr = lowestIdx(illegalV);
    end
`ifdef TL_CONFLICT_MONITOR_WDOG_EN
    else if (wdogCnt_q == WDOG_CYC) begin
      detCode = FC_WDOG;
    end
`endif
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= ST_ALLRED;
      timer_q  <= '0;
      out_q    <= {4{LT_RED}};
      code_q   <= FC_NONE;
      appr_q   <= 2'd0;
      prev_q   <= {4{LT_RED}};
      yelCnt_q <= '0;
    end else begin
      prev_q <= stable;
      for (int i = 0; i < 4; i++) begin
        if (stable[i] != LT_YEL) yelCnt_q[i] <= '0;
        else if (yelCnt_q[i] < YW'(MIN_YELLOW_CYC)) yelCnt_q[i] <= yelCnt_q[i] + 1'b1;
      end
      case (state_q)
        ST_ALLRED: begin
          out_q <= {4{LT_RED}};
          if (timer_q == ALLRED_CYC - 1) begin
            timer_q <= '0;
            if (allRed) state_q <= ST_RUN;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        ST_RUN: begin
          if (detCode != FC_NONE) begin
            state_q <= ST_FAULT;
            code_q  <= detCode;
            appr_q  <= detAppr;
            out_q   <= {4{LT_RED}};
            timer_q <= '0;
          end else begin
            out_q <= stable;
          end
        end
        ST_FAULT: begin
          if (clear_fault && allRed) begin
            state_q <= ST_ALLRED;
            code_q  <= FC_NONE;
            appr_q  <= 2'd0;
            out_q   <= {4{LT_RED}};
            timer_q <= '0;
          end else if (timer_q == FLASH_HALF_CYC - 1) begin
            timer_q <= '0;
            out_q   <= (out_q[0] == LT_RED) ? {4{LT_OFF}} : {4{LT_RED}};
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        default: state_q <= ST_ALLRED;
      endcase
    end
  end

  assign tl_0_out       = out_q[0];
  assign tl_1_out       = out_q[1];
  assign tl_2_out       = out_q[2];
  assign tl_3_out       = out_q[3];
  assign fault          = (state_q == ST_FAULT);
  assign fault_code     = code_q;
  assign fault_approach = appr_q;

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Directed scoreboard bench for tl_conflict_monitor with shortened timing parameters.
// Watchdog steps run only when TL_CONFLICT_MONITOR_WDOG_EN is defined.
module tb_tl_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [2:0] tl_0_in, tl_1_in, tl_2_in, tl_3_in;
  logic       clear_fault;
  logic       wdog_kick;
  logic [2:0] tl_0_out, tl_1_out, tl_2_out, tl_3_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_approach;

  bit kickEn = 1'b1;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    bit         chkOuts;
    logic [11:0] outs;
    logic       flt;
    logic [2:0] code;
    logic [1:0] appr;
  } exp_t;

  exp_t sbQ[$];

  tl_conflict_monitor #(
    .GLITCH_CYC    (2),
    .MIN_YELLOW_CYC(10),
    .ALLRED_CYC    (8),
    .FLASH_HALF_CYC(4),
    .WDOG_CYC      (50)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .tl_0_in       (tl_0_in),
    .tl_1_in       (tl_1_in),
    .tl_2_in       (tl_2_in),
    .tl_3_in       (tl_3_in),
    .clear_fault   (clear_fault),
    .wdog_kick     (wdog_kick),
    .tl_0_out      (tl_0_out),
    .tl_1_out      (tl_1_out),
    .tl_2_out      (tl_2_out),
    .tl_3_out      (tl_3_out),
    .fault         (fault),
    .fault_code    (fault_code),
    .fault_approach(fault_approach)
  );

  always #5 clk_clk = ~clk_clk;

  // Software heartbeat every 20 cycles unless a step deliberately starves it.
  initial begin
    wdog_kick = 1'b0;
    forever begin
      repeat (20) @(posedge clk_clk);
      #2 wdog_kick = kickEn;
      @(posedge clk_clk);
      #2 wdog_kick = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] t0, t1, t2, t3);
    tl_0_in = t0;
    tl_1_in = t1;
    tl_2_in = t2;
    tl_3_in = t3;
  endtask

  task automatic pushExpect(input string tag, input bit chkOuts, input logic [11:0] outs,
                            input logic flt, input logic [2:0] code, input logic [1:0] appr);
    exp_t e;
    e.tag = tag; e.chkOuts = chkOuts; e.outs = outs;
    e.flt = flt; e.code = code; e.appr = appr;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [11:0] obs;
    e   = sbQ.pop_front();
    obs = {tl_3_out, tl_2_out, tl_1_out, tl_0_out};
    if (e.chkOuts) begin
      checks++;
      assert (obs === e.outs) else begin
        errors++;
        $error("[TB] FAIL %s outs: observed %h expected %h", e.tag, obs, e.outs);
      end
    end
    checks++;
    assert (fault === e.flt) else begin
      errors++;
      $error("[TB] FAIL %s fault: observed %b expected %b", e.tag, fault, e.flt);
    end
    checks++;
    assert (fault_code === e.code) else begin
      errors++;
      $error("[TB] FAIL %s fault_code: observed %0d expected %0d", e.tag, fault_code, e.code);
    end
    checks++;
    assert (fault_approach === e.appr) else begin
      errors++;
      $error("[TB] FAIL %s fault_approach: observed %0d expected %0d", e.tag, fault_approach, e.appr);
    end
  endtask

  task automatic pulseClear();
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
  endtask

  // Return to a clean ST_RUN with all approaches red.
  task automatic recover(input string tag);
    applyStimulus(R, R, R, R);
    tick(5);
    pulseClear();
    pushExpect(tag, 1'b1, {R, R, R, R}, 1'b0, 3'd0, 2'd0);
    checkOutput();
    tick(10);
  endtask

  initial begin
    reset_reset = 1'b1;
    clear_fault = 1'b0;
    applyStimulus(R, R, R, R);
    tick(3);
    reset_reset = 1'b0;

    // Reset state and all-red hold, then a green passes through.
    pushExpect("reset", 1'b1, {R, R, R, R}, 1'b0, 3'd0, 2'd0);
    checkOutput();
    tick(6);
    pushExpect("allred_hold", 1'b1, {R, R, R, R}, 1'b0, 3'd0, 2'd0);
    checkOutput();
    tick(4);
    applyStimulus(G, R, R, R);
    pushExpect("tl0_green", 1'b1, {R, R, R, G}, 1'b0, 3'd0, 2'd0);
    tick(4);
    checkOutput();

    // One-cycle glitch is filtered; a held cross-axis green is a conflict.
    applyStimulus(G, G, R, R);
    tick(1);
    applyStimulus(G, R, R, R);
    pushExpect("glitch_filtered", 1'b1, {R, R, R, G}, 1'b0, 3'd0, 2'd0);
    tick(6);
    checkOutput();
    applyStimulus(G, G, R, R);
    pushExpect("conflict_entry", 1'b1, {R, R, R, R}, 1'b1, 3'd2, 2'd0);
    tick(4);
    checkOutput();
    pushExpect("flash_red_end", 1'b1, {R, R, R, R}, 1'b1, 3'd2, 2'd0);
    tick(3);
    checkOutput();
    pushExpect("flash_off", 1'b1, {O, O, O, O}, 1'b1, 3'd2, 2'd0);
    tick(1);
    checkOutput();
    pushExpect("flash_off_end", 1'b1, {O, O, O, O}, 1'b1, 3'd2, 2'd0);
    tick(3);
    checkOutput();
    pushExpect("flash_red_again", 1'b1, {R, R, R, R}, 1'b1, 3'd2, 2'd0);
    tick(1);
    checkOutput();

    // Clear is ignored while any approach is not red.
    pulseClear();
    pushExpect("clear_ignored", 1'b0, 12'h0, 1'b1, 3'd2, 2'd0);
    checkOutput();
    recover("clear_accepted");

    // Short yellow on approach 2.
    applyStimulus(R, R, G, R);
    pushExpect("tl2_green", 1'b1, {R, G, R, R}, 1'b0, 3'd0, 2'd0);
    tick(6);
    checkOutput();
    applyStimulus(R, R, Y, R);
    pushExpect("tl2_yellow", 1'b1, {R, Y, R, R}, 1'b0, 3'd0, 2'd0);
    tick(5);
    checkOutput();
    applyStimulus(R, R, R, R);
    pushExpect("short_yellow", 1'b0, 12'h0, 1'b1, 3'd3, 2'd2);
    tick(6);
    checkOutput();
    recover("recover_short");

    // Full-length yellow is legal.
    applyStimulus(R, R, G, R);
    tick(6);
    applyStimulus(R, R, Y, R);
    tick(12);
    applyStimulus(R, R, R, R);
    pushExpect("long_yellow_ok", 1'b1, {R, R, R, R}, 1'b0, 3'd0, 2'd0);
    tick(6);
    checkOutput();

    // Green straight to red on approach 3.
    applyStimulus(R, R, R, G);
    pushExpect("tl3_green", 1'b1, {G, R, R, R}, 1'b0, 3'd0, 2'd0);
    tick(6);
    checkOutput();
    applyStimulus(R, R, R, R);
    pushExpect("illegal_g2r", 1'b0, 12'h0, 1'b1, 3'd4, 2'd3);
    tick(6);
    checkOutput();
    recover("recover_illegal");

    // Invalid code on approach 1.
    applyStimulus(R, 3'b011, R, R);
    pushExpect("invalid_tl1", 1'b0, 12'h0, 1'b1, 3'd1, 2'd1);
    tick(6);
    checkOutput();
    recover("recover_invalid");

    // Invalid and illegal transition together: invalid wins.
    applyStimulus(R, R, R, G);
    tick(6);
    applyStimulus(R, 3'b011, R, R);
    pushExpect("priority_invalid", 1'b0, 12'h0, 1'b1, 3'd1, 2'd1);
    tick(6);
    checkOutput();
    recover("recover_priority");

`ifdef TL_CONFLICT_MONITOR_WDOG_EN
    // Regular kicks keep the watchdog quiet; starving it raises code 5.
    pushExpect("wdog_kicked", 1'b1, {R, R, R, R}, 1'b0, 3'd0, 2'd0);
    tick(60);
    checkOutput();
    kickEn = 1'b0;
    pushExpect("wdog_timeout", 1'b0, 12'h0, 1'b1, 3'd5, 2'd0);
    tick(60);
    checkOutput();
    kickEn = 1'b1;
    recover("recover_wdog");
`endif

    // Reset during the dark half of the flash.
    applyStimulus(G, G, R, R);
    tick(4);
    pushExpect("pre_reset_off", 1'b1, {O, O, O, O}, 1'b1, 3'd2, 2'd0);
    tick(5);
    checkOutput();
    reset_reset = 1'b1;
    pushExpect("reset_mid_flash", 1'b1, {R, R, R, R}, 1'b0, 3'd0, 2'd0);
    tick(1);
    checkOutput();
    applyStimulus(R, R, R, R);
    tick(2);
    reset_reset = 1'b0;
    pushExpect("post_reset_run", 1'b1, {R, R, R, R}, 1'b0, 3'd0, 2'd0);
    tick(12);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
